// File: rtl/jk_seq_counter_if.sv
// Control and observation bundle for the JK-stage modulo counter.
// The master side drives the controls; the counter is the slave.
interface jk_seq_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_max;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic [WIDTH-1:0] jk_j;
  logic [WIDTH-1:0] jk_k;

  modport master (
    output en, up, load, load_val, mod_max,
    input  count, tc, jk_j, jk_k
  );

  modport slave (
    input  en, up, load, load_val, mod_max,
    output count, tc, jk_j, jk_k
  );
endinterface

// File: rtl/jk_seq_counter.sv
// Up/down modulo counter (range 0..mod_max) built from one JK flop per bit.
// The J/K drives are exported so the next state is observable before the edge.
module jk_stage (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= 1'b0;
    else        q <= (j & ~q) | (~k & q);
endmodule

module jk_seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  jk_seq_counter_if.slave    bus
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;
  logic             wrap;
  logic             tc_q;

  jk_stage u_stage [WIDTH-1:0] (
    .clk   (clk),
    .reset (reset),
    .j     (j_drv),
    .k     (k_drv),
    .q     (cnt)
  );

  // Load forces each bit (set/reset); counting toggles only the changing bits,
  // so J and K are never both high on a bit that keeps its value.
  always_comb begin
    tgt   = cnt;
    wrap  = 1'b0;
    j_drv = '0;
    k_drv = '0;
    lim   = (bus.load_val > bus.mod_max) ? bus.mod_max : bus.load_val;
    if (bus.load) begin
      j_drv = lim;
      k_drv = ~lim;
    end else if (bus.en) begin
      if (bus.up) begin
        if (cnt < bus.mod_max) tgt = cnt + ONE;
        else begin
          tgt  = '0;
          wrap = 1'b1;
        end
      end else if (cnt == '0) begin
        tgt  = bus.mod_max;
        wrap = 1'b1;
      end else if (cnt > bus.mod_max) begin
        tgt = bus.mod_max;
      end else begin
        tgt = cnt - ONE;
      end
      j_drv = tgt ^ cnt;
      k_drv = tgt ^ cnt;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) tc_q <= 1'b0;
    else        tc_q <= wrap;

  assign bus.count = cnt;
  assign bus.tc    = tc_q;
  assign bus.jk_j  = j_drv;
  assign bus.jk_k  = k_drv;
endmodule

// File: tb/tb_jk_seq_counter.sv
// Scoreboard bench: a reference model pushes expected {tc,count} per driven
// cycle; entries are popped and compared after the following rising edge.
module tb_jk_seq_counter;
  localparam int W = 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [W-1:0] mcount;
  logic         mtc;
  logic [W:0]   exp_q[$];

  jk_seq_counter_if #(.WIDTH(W)) bus ();

  jk_seq_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // returns {wrap, next}
  function automatic logic [W:0] ref_next(input logic [W-1:0] c, input logic ld,
      input logic [W-1:0] lv, input logic e, input logic u, input logic [W-1:0] mm);
    if (ld)     return {1'b0, (lv > mm) ? mm : lv};
    if (!e)     return {1'b0, c};
    if (u)      return (c < mm) ? {1'b0, W'(c + 1)} : {1'b1, {W{1'b0}}};
    if (c == 0) return {1'b1, mm};
    if (c > mm) return {1'b0, mm};
    return {1'b0, W'(c - 1)};
  endfunction

  task automatic step(input logic ld, input logic [W-1:0] lv, input logic e,
                      input logic u, input logic [W-1:0] mm);
    logic [W:0]   r;
    logic [W-1:0] nxt;
    logic [W-1:0] nnxt;
    logic [W:0]   ev;
    bus.load = ld; bus.load_val = lv; bus.en = e; bus.up = u; bus.mod_max = mm;
    #1;
    r    = ref_next(mcount, ld, lv, e, u, mm);
    nxt  = r[W-1:0];
    nnxt = ~nxt;
    chk("jk_next", (bus.jk_j & ~bus.count) | (~bus.jk_k & bus.count), nxt);
    chk("jk_both", bus.jk_j & bus.jk_k & ~(nxt ^ bus.count), 0);
    if (!ld && !e) begin
      chk("hold_j", bus.jk_j, 0);
      chk("hold_k", bus.jk_k, 0);
    end
    if (ld) begin
      chk("load_j", bus.jk_j, nxt);
      chk("load_k", bus.jk_k, nnxt);
    end
    mcount = nxt;
    mtc    = r[W];
    exp_q.push_back({mtc, mcount});
    @(posedge clk);
    @(negedge clk);
    ev = exp_q.pop_front();
    chk("count", bus.count, ev[W-1:0]);
    chk("tc", bus.tc, ev[W]);
  endtask

  // Assert reset between edges, check the async clear, release on a falling edge.
  task automatic mid_reset();
    reset = 1'b0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_tc", bus.tc, 0);
    mcount = '0;
    mtc    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", bus.count, 0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b0;
    bus.load_val = '0; bus.mod_max = 4'd9;
    mcount = '0; mtc = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("por_count", bus.count, 0);
    chk("por_tc", bus.tc, 0);
    @(negedge clk);
    chk("por_edge", bus.count, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) step(1'b0, 4'd0, 1'b1, 1'b1, 4'd9);
    chk("up_end", mcount, 2);

    step(1'b1, 4'd3, 1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 4'd9);
    chk("dn_end", mcount, 8);

    step(1'b1, 4'd12, 1'b1, 1'b1, 4'd9);
    step(1'b0, 4'd0, 1'b1, 1'b1, 4'd9);

    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b1, 4'd0);
    mid_reset();

    step(1'b1, 4'd6, 1'b0, 1'b1, 4'd9);
    mid_reset();
    step(1'b0, 4'd0, 1'b1, 1'b1, 4'd9);

    step(1'b1, 4'd8, 1'b0, 1'b0, 4'd9);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd5);
    step(1'b0, 4'd0, 1'b0, 1'b0, 4'd5);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd15);
    step(1'b1, 4'd15, 1'b0, 1'b1, 4'd15);
    step(1'b0, 4'd0, 1'b1, 1'b1, 4'd15);

    for (int i = 0; i < 300; i++)
      step(($urandom_range(7) == 0), 4'($urandom_range(15)), ($urandom_range(3) != 0),
           1'($urandom_range(1)), (i % 40 < 30) ? 4'd11 : 4'($urandom_range(15)));

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
